// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and helpers for the GPU memory-channel arbiters
package gpu_pkg;

  typedef enum logic [1:0] {PM_IDLE, PM_WAIT, PM_RELEASE} pm_arb_state_t;

  // Width of a core index; a single core still gets a 1-bit index.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker starting after the last grant
module rr_priority_picker
  import gpu_pkg::*;
#(
  parameter int N = 2,
  localparam int GW = idx_bits(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_grant_i,
  output logic [GW-1:0] grant_o,
  output logic          grant_valid_o
);

  logic [GW-1:0] cand;

  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    grant_o       = last_grant_i;
    grant_valid_o = 1'b0;
    cand          = last_grant_i;
    for (int k = N; k >= 1; k--) begin
      cand = GW'((int'(last_grant_i) + k) % N);
      if (req_i[cand]) begin
        grant_o       = cand;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/program_mem_arbiter.sv
// rtl/program_mem_arbiter.sv - round-robin program-memory fetch arbiter with same-address broadcast
module program_mem_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_CORES             = 2,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             core_read_valid,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] core_read_address [NUM_CORES],
  output logic [NUM_CORES-1:0]             core_read_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] core_read_data [NUM_CORES],
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data
);

  localparam int GW = idx_bits(NUM_CORES);

  pm_arb_state_t                    state_q;
  logic [GW-1:0]                    last_grant_q;
  logic [NUM_CORES-1:0]             served_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q;
  logic                             mem_valid_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] data_q [NUM_CORES];

  logic [GW-1:0]        grant;
  logic                 grant_valid;
  logic [NUM_CORES-1:0] match_mask;
  logic [NUM_CORES-1:0] served_d;

  rr_priority_picker #(.N(NUM_CORES)) u_picker (
    .req_i         (core_read_valid & ~served_q),
    .last_grant_i  (last_grant_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    match_mask = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      match_mask[i] = core_read_valid[i] && (core_read_address[i] == addr_q);
    end
    served_d = served_q & core_read_valid;
  end

  // The served mask doubles as the registered per-core ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PM_IDLE;
      last_grant_q <= GW'(NUM_CORES - 1);
      served_q     <= '0;
      addr_q       <= '0;
      mem_valid_q  <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        PM_IDLE: begin
          if (grant_valid) begin
            addr_q       <= core_read_address[grant];
            mem_valid_q  <= 1'b1;
            last_grant_q <= grant;
            state_q      <= PM_WAIT;
          end
        end
        PM_WAIT: begin
          if (mem_read_ready) begin
            mem_valid_q <= 1'b0;
            served_q    <= match_mask;
            for (int i = 0; i < NUM_CORES; i++) begin
              if (match_mask[i]) begin
                data_q[i] <= mem_read_data;
              end
            end
            state_q <= PM_RELEASE;
          end
        end
        PM_RELEASE: begin
          served_q <= served_d;
          if (served_d == '0) begin
            state_q <= PM_IDLE;
          end
        end
        default: state_q <= PM_IDLE;
      endcase
    end
  end

  assign core_read_ready  = served_q;
  assign core_read_data   = data_q;
  assign mem_read_valid   = mem_valid_q;
  assign mem_read_address = addr_q;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// tb/tb_program_mem_arbiter.sv - self-checking bench for program_mem_arbiter
module tb_program_mem_arbiter;

  localparam int N  = 2;
  localparam int AB = 8;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  core_read_valid = '0;
  logic [AB-1:0] core_read_address [N];
  logic [N-1:0]  core_read_ready;
  logic [DB-1:0] core_read_data [N];
  logic          mem_read_valid;
  logic [AB-1:0] mem_read_address;
  logic          mem_read_ready = 1'b0;
  logic [DB-1:0] mem_read_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  program_mem_arbiter #(
    .NUM_CORES(N), .PROGRAM_MEM_ADDR_BITS(AB), .PROGRAM_MEM_DATA_BITS(DB)
  ) dut (
    .clk               (clk),
    .reset             (rst_n),
    .core_read_valid   (core_read_valid),
    .core_read_address (core_read_address),
    .core_read_ready   (core_read_ready),
    .core_read_data    (core_read_data),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: the arbiter is either free, fetching one address, or
  // waiting for every core fed by the last fetch to let go.
  int            ph = 0;
  int            mlast = N - 1;
  int            g;
  bit            found;
  bit            any_ready;
  int            nsrv;
  int            broadcasts = 0;
  logic [AB-1:0] maddr = '0;
  bit            mready [N];
  logic [DB-1:0] mdata [N];
  bit            sv [N];
  logic [AB-1:0] sa [N];
  logic          sr;
  logic [DB-1:0] sd;
  int            fetch_seen = 0;
  logic          prev_mv = 1'b0;

  initial begin : model
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ph = 0;
        mlast = N - 1;
        for (int i = 0; i < N; i++) mready[i] = 1'b0;
        prev_mv = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          sv[i] = core_read_valid[i];
          sa[i] = core_read_address[i];
        end
        sr = mem_read_ready;
        sd = mem_read_data;
        if (ph == 0) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            if (!found && sv[(mlast + k) % N]) begin
              g = (mlast + k) % N;
              found = 1'b1;
            end
          end
          if (found) begin
            maddr = sa[g];
            mlast = g;
            ph = 1;
          end
        end else if (ph == 1) begin
          if (sr) begin
            nsrv = 0;
            for (int i = 0; i < N; i++) begin
              if (sv[i] && sa[i] == maddr) begin
                mready[i] = 1'b1;
                mdata[i] = sd;
                nsrv++;
              end
            end
            if (nsrv > 1) broadcasts++;
            ph = 2;
          end
        end else begin
          any_ready = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (!sv[i]) mready[i] = 1'b0;
            if (mready[i]) any_ready = 1'b1;
          end
          if (!any_ready) ph = 0;
        end
        #1;
        check("m_mem_valid", 32'(mem_read_valid), 32'(ph == 1));
        if (ph == 1) check("m_mem_addr", 32'(mem_read_address), 32'(maddr));
        for (int i = 0; i < N; i++) begin
          check("m_ready", 32'(core_read_ready[i]), 32'(mready[i]));
          if (mready[i]) check("m_data", 32'(core_read_data[i]), 32'(mdata[i]));
        end
        if (mem_read_valid && !prev_mv) fetch_seen++;
        prev_mv = mem_read_valid;
      end
    end
  end

  task automatic wait_mem_valid(input string tag);
    int n;
    n = 0;
    while (!mem_read_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(mem_read_valid), 32'd1);
  endtask

  task automatic mem_respond(input logic [DB-1:0] d);
    mem_read_ready = 1'b1;
    mem_read_data  = d;
    @(negedge clk);
    mem_read_ready = 1'b0;
  endtask

  task automatic drain();
    core_read_valid = '0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      mem_read_ready = mem_read_valid;
      mem_read_data  = 16'h0bad;
    end
    mem_read_ready = 1'b0;
    @(negedge clk);
    check("drain_mem_valid", 32'(mem_read_valid), 32'd0);
    check("drain_ready", 32'(core_read_ready), 32'd0);
  endtask

  int cst [N];
  int cnt [N];
  int wt [N];
  int max_wt = 0;
  bit resp_done = 1'b0;
  int mdly = 0;
  int f0;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < N; i++) core_read_address[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_valid", 32'(mem_read_valid), 32'd0);
    check("rst_mem_addr", 32'(mem_read_address), 32'd0);
    check("rst_ready", 32'(core_read_ready), 32'd0);
    check("rst_data0", 32'(core_read_data[0]), 32'd0);
    check("rst_data1", 32'(core_read_data[1]), 32'd0);
    rst_n = 1'b1;

    // single core fetch, memory answers 3 cycles after the request
    @(negedge clk);
    f0 = fetch_seen;
    core_read_valid[0] = 1'b1;
    core_read_address[0] = 8'h05;
    @(negedge clk);
    check("t1_mem_valid", 32'(mem_read_valid), 32'd1);
    check("t1_mem_addr", 32'(mem_read_address), 32'h05);
    repeat (2) @(negedge clk);
    check("t1_not_ready_yet", 32'(core_read_ready), 32'd0);
    mem_respond(16'hA1B2);
    check("t1_ready", 32'(core_read_ready), 32'b01);
    check("t1_data", 32'(core_read_data[0]), 32'hA1B2);
    check("t1_mem_valid_low", 32'(mem_read_valid), 32'd0);
    core_read_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_ready_fall", 32'(core_read_ready[0]), 32'd0);
    check("t1_fetch_count", 32'(fetch_seen - f0), 32'd1);

    // same address from both cores: one fetch broadcast to both
    @(negedge clk);
    f0 = fetch_seen;
    core_read_valid = 2'b11;
    core_read_address[0] = 8'h10;
    core_read_address[1] = 8'h10;
    wait_mem_valid("t2_mem_valid");
    check("t2_mem_addr", 32'(mem_read_address), 32'h10);
    mem_respond(16'h1234);
    check("t2_ready", 32'(core_read_ready), 32'b11);
    check("t2_data0", 32'(core_read_data[0]), 32'h1234);
    check("t2_data1", 32'(core_read_data[1]), 32'h1234);
    core_read_valid = '0;
    @(negedge clk);
    check("t2_fetch_count", 32'(fetch_seen - f0), 32'd1);

    // different addresses under continuous contention alternate 0,1,0,1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    f0 = fetch_seen;
    core_read_valid = 2'b11;
    core_read_address[0] = 8'h10;
    core_read_address[1] = 8'h20;
    for (int k = 0; k < 4; k++) begin
      wait_mem_valid("t3_mem_valid");
      check("t3_order_addr", 32'(mem_read_address), (k % 2 == 0) ? 32'h10 : 32'h20);
      mem_respond(DB'(16'h3000 + k));
      check("t3_ready", 32'(core_read_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
      core_read_valid[k % 2] = 1'b0;
      @(negedge clk);
      core_read_valid[k % 2] = 1'b1;
    end
    check("t3_fetch_count", 32'(fetch_seen - f0), 32'd4);
    drain();

    // core0 holds after ready; core1 waits until two cycles after the drop
    core_read_valid[0] = 1'b1;
    core_read_address[0] = 8'h40;
    wait_mem_valid("t4_mem_valid0");
    mem_respond(16'h4444);
    core_read_valid[1] = 1'b1;
    core_read_address[1] = 8'h30;
    for (int j = 0; j < 5; j++) begin
      check("t4_hold_ready", 32'(core_read_ready[0]), 32'd1);
      check("t4_hold_no_fetch", 32'(mem_read_valid), 32'd0);
      @(negedge clk);
    end
    core_read_valid[0] = 1'b0;
    @(negedge clk);
    check("t4_ready_fall", 32'(core_read_ready[0]), 32'd0);
    check("t4_no_fetch_yet", 32'(mem_read_valid), 32'd0);
    @(negedge clk);
    check("t4_fetch1", 32'(mem_read_valid), 32'd1);
    check("t4_fetch1_addr", 32'(mem_read_address), 32'h30);
    mem_respond(16'h3030);
    check("t4_ready1", 32'(core_read_ready), 32'b10);
    check("t4_data1", 32'(core_read_data[1]), 32'h3030);
    drain();

    // reset while a fetch is outstanding
    core_read_valid[0] = 1'b1;
    core_read_address[0] = 8'h50;
    wait_mem_valid("t5_mem_valid");
    rst_n = 1'b0;
    #1;
    check("t5_async_mem_valid", 32'(mem_read_valid), 32'd0);
    check("t5_async_ready", 32'(core_read_ready), 32'd0);
    check("t5_async_addr", 32'(mem_read_address), 32'd0);
    mem_read_ready = 1'b1;
    mem_read_data = 16'hDEAD;
    @(negedge clk);
    mem_read_ready = 1'b0;
    rst_n = 1'b1;
    check("t5_stale_ignored", 32'(core_read_ready), 32'd0);
    wait_mem_valid("t5_refetch");
    check("t5_refetch_addr", 32'(mem_read_address), 32'h50);
    mem_respond(16'hBEEF);
    check("t5_ready", 32'(core_read_ready[0]), 32'd1);
    check("t5_fresh_data", 32'(core_read_data[0]), 32'hBEEF);
    drain();

    // drop and immediately re-request a new address
    core_read_valid[0] = 1'b1;
    core_read_address[0] = 8'h05;
    wait_mem_valid("t6_mem_valid0");
    mem_respond(16'h1111);
    check("t6_data0", 32'(core_read_data[0]), 32'h1111);
    core_read_valid[0] = 1'b0;
    @(negedge clk);
    check("t6_ready_fall", 32'(core_read_ready[0]), 32'd0);
    f0 = fetch_seen;
    core_read_valid[0] = 1'b1;
    core_read_address[0] = 8'h06;
    wait_mem_valid("t6_mem_valid1");
    check("t6_addr", 32'(mem_read_address), 32'h06);
    check("t6_no_stale_ready", 32'(core_read_ready[0]), 32'd0);
    mem_respond(16'h2222);
    check("t6_data1", 32'(core_read_data[0]), 32'h2222);
    check("t6_fetch_count", 32'(fetch_seen - f0), 32'd1);
    drain();

    // randomized traffic over a small address set, random memory latency,
    // stray memory strobes while no fetch is outstanding
    for (int i = 0; i < N; i++) begin
      cst[i] = 0;
      cnt[i] = 0;
      wt[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (cst[i] == 0) begin
          if (cnt[i] > 0) cnt[i]--;
          else if (!core_read_ready[i] && $urandom_range(0, 2) == 0) begin
            core_read_valid[i] = 1'b1;
            core_read_address[i] = AB'($urandom_range(0, 3));
            cst[i] = 1;
            wt[i] = 0;
          end
        end else if (cst[i] == 1) begin
          if (core_read_ready[i]) begin
            cst[i] = 2;
            cnt[i] = $urandom_range(0, 2);
          end else begin
            wt[i]++;
            if (wt[i] > max_wt) max_wt = wt[i];
          end
        end else begin
          if (cnt[i] > 0) cnt[i]--;
          else begin
            core_read_valid[i] = 1'b0;
            cst[i] = 0;
            cnt[i] = $urandom_range(0, 3);
          end
        end
      end
      if (mem_read_valid && !resp_done) begin
        if (mdly == 0) begin
          mem_read_ready = 1'b1;
          mem_read_data = DB'($urandom);
          resp_done = 1'b1;
        end else begin
          mdly--;
          mem_read_ready = 1'b0;
        end
      end else if (!mem_read_valid) begin
        resp_done = 1'b0;
        mdly = $urandom_range(0, 3);
        mem_read_ready = ($urandom_range(0, 7) == 0);
        mem_read_data = DB'($urandom);
      end else begin
        mem_read_ready = 1'b0;
      end
    end
    drain();
    check("rand_max_wait_bounded", 32'(max_wt < 100), 32'd1);
    check("rand_broadcast_seen", 32'(broadcasts > 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
